cmp_rr_scheduler: RTL

- Shares one magnitude-compare datapath (A>B, A==B, A<B) between NUM_REQ requesters.
- Round-robin arbitration, one comparison per clock.
- Result is registered and returned on a single response channel tagged with the requester ID.
- Sits between the requesting blocks and the comparator. Includes a saturating completed-compare counter for debug.

---
 rtl/cmp_rr_scheduler.sv | 114 +++++++++++
 1 files changed

// File: rtl/cmp_rr_scheduler.sv
// Round-robin scheduler sharing one unsigned magnitude comparator among NUM_REQ
// requesters; the registered result returns on a single ID-tagged response channel.
module cmp_rr_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 2,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic                       rsp_gt,
    output logic                       rsp_eq,
    output logic                       rsp_lt,
    output logic [CNT_W-1:0]           cmp_count,
    output logic                       busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic               r_gt;
    logic               r_eq;
    logic               r_lt;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_can_accept;
    logic [ID_W:0]      w_pick;
    logic               w_found;
    logic [ID_W-1:0]    w_gnt_idx;
    logic               w_accept;
    logic               w_rsp_fire;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;

    // First asserted valid at or after pointer p (with wrap); MSB flags a hit.
    function automatic logic [ID_W:0] f_pick(input logic [NUM_REQ-1:0] v,
                                             input logic [ID_W-1:0]    p);
        logic [ID_W:0] res;
        int unsigned   idx;
        res = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            idx = (32'(p) + 32'(k)) % NUM_REQ;
            if (v[ID_W'(idx)]) begin
                res = {1'b1, ID_W'(idx)};
            end
        end
        return res;
    endfunction

    assign w_can_accept = (r_state == ST_IDLE) | rsp_ready;
    assign w_pick       = f_pick(req_valid, r_ptr);
    assign w_found      = w_pick[ID_W];
    assign w_gnt_idx    = w_pick[ID_W-1:0];
    // Grant is suppressed while reset is asserted even though the FSM sits in IDLE.
    assign w_accept     = rst_n & w_can_accept & w_found;
    assign w_rsp_fire   = (r_state == ST_HOLD) & rsp_ready;

    assign w_a = req_a[32'(w_gnt_idx) * WIDTH +: WIDTH];
    assign w_b = req_b[32'(w_gnt_idx) * WIDTH +: WIDTH];

    assign req_ready = w_accept ? (NUM_REQ'(1) << w_gnt_idx) : '0;

    // Response FSM, result register, rr pointer and debug counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_id    <= '0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_rsp_fire && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_accept) begin
                r_state <= ST_HOLD;
                r_id    <= w_gnt_idx;
                r_gt    <= (w_a > w_b);
                r_eq    <= (w_a == w_b);
                r_lt    <= (w_a < w_b);
                r_ptr   <= (32'(w_gnt_idx) == NUM_REQ - 1) ? '0 : w_gnt_idx + ID_W'(1);
            end else begin
                case (r_state)
                    ST_IDLE: r_state <= ST_IDLE;
                    ST_HOLD: if (rsp_ready) r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign rsp_valid = (r_state == ST_HOLD);
    assign busy      = (r_state == ST_HOLD);
    assign rsp_id    = r_id;
    assign rsp_gt    = r_gt;
    assign rsp_eq    = r_eq;
    assign rsp_lt    = r_lt;
    assign cmp_count = r_cnt;

endmodule
